vga_led_decoder: RTL

Receive-side counterpart of the seven-segment VGA emulator: it watches a 640x480 VGA stream (25 MHz pixel clock qualified inside the 50 MHz domain), recovers pixel coordinates, samples one point per segment of each of the eight emulated digits, and rebuilds the eight 8-bit segment bytes. It sits on the board-test and loopback path, so that the displayed digits can be checked against the values that drove them.

---
 rtl/vga_led_decoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_led_decoder.sv
// Recovers the eight seven-segment bytes drawn by the VGA emulator by sampling
// one pixel per segment and publishing a frame only when its geometry is clean.
module vga_led_decoder #(
    parameter logic [7:0] LIT_THRESH = 8'h80,
    parameter int         H_PIX      = 640,
    parameter int         V_LINES    = 480,
    // Shrinks the digit cell and sample points by 2**SCALE_LG; 0 gives the 64x128 cell.
    parameter int         SCALE_LG   = 0
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       VGA_CLK,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_BLANK_n,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5,
    output logic [7:0] hex6,
    output logic [7:0] hex7,
    output logic       frame_done,
    output logic       locked,
    output logic       fsm_state
);

    typedef enum logic {
        SEEK  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam int         CW     = 6 - SCALE_LG;
    localparam int         CH     = 7 - SCALE_LG;
    localparam logic [9:0] X_MASK = 10'((1 << CW) - 1);
    localparam logic [8:0] Y_MASK = 9'((1 << CH) - 1);
    localparam logic [9:0] X_LO   = 10'(1 << CW);
    localparam logic [9:0] X_HI   = 10'(9 << CW);
    localparam int SEG_X [8] = '{20, 44, 44, 20, 4, 4, 20, 52};
    localparam int SEG_Y [8] = '{4, 28, 76, 100, 76, 28, 52, 116};

    state_t state, state_next;

    logic       clk_r, clk_q, vs_r, vs_q, blank_r, blank_q;
    logic [7:0] r_r;
    logic       pix, vs_fall, blank_fall;

    logic [9:0] x;
    logic [8:0] y;
    logic       geom_err;
    logic [7:0][7:0] shadow;
    logic [7:0][7:0] hex_q;

    logic [9:0] lx;
    logic [8:0] ly;
    logic       in_win;
    logic       seg_hit;
    logic [2:0] seg_sel;
    logic [2:0] hex_idx;
    logic       publish, drop;

    logic unused_ok;
    assign unused_ok = ^{VGA_G, VGA_B, VGA_HS};

    assign pix        = clk_r & ~clk_q;
    assign vs_fall    = vs_q & ~vs_r;
    assign blank_fall = blank_q & ~blank_r;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            clk_r   <= 1'b0;
            clk_q   <= 1'b0;
            vs_r    <= 1'b0;
            vs_q    <= 1'b0;
            blank_r <= 1'b0;
            blank_q <= 1'b0;
            r_r     <= 8'h00;
        end else begin
            clk_r   <= VGA_CLK;
            clk_q   <= clk_r;
            vs_r    <= VGA_VS;
            vs_q    <= vs_r;
            blank_r <= VGA_BLANK_n;
            blank_q <= blank_r;
            r_r     <= VGA_R;
        end
    end

    // Digit column 8 (the rightmost cell) wraps to hex7 through the 3-bit subtract.
    assign lx      = x & X_MASK;
    assign ly      = y & Y_MASK;
    assign in_win  = (x >= X_LO) && (x < X_HI) && ((y >> CH) == 9'd1);
    assign hex_idx = 3'(x >> CW) - 3'd1;

    always_comb begin
        seg_hit = 1'b0;
        seg_sel = 3'd0;
        if (in_win) begin
            for (int i = 0; i < 8; i++) begin
                if (!seg_hit && lx == 10'(SEG_X[i] >> SCALE_LG) &&
                    ly == 9'(SEG_Y[i] >> SCALE_LG)) begin
                    seg_hit = 1'b1;
                    seg_sel = 3'(i);
                end
            end
        end
    end

    // A VS fall takes priority over any pixel or line event in the same cycle.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            x        <= 10'd0;
            y        <= 9'd0;
            geom_err <= 1'b0;
            shadow   <= '0;
        end else if (vs_fall) begin
            x        <= 10'd0;
            y        <= 9'd0;
            geom_err <= 1'b0;
            shadow   <= '0;
        end else begin
            if (pix) begin
                if (blank_r) begin
                    if (x != '1) x <= x + 10'd1;
                    if (seg_hit) shadow[hex_idx][seg_sel] <= (r_r >= LIT_THRESH);
                end else begin
                    x <= 10'd0;
                end
            end
            if (blank_fall) begin
                if (y != '1) y <= y + 9'd1;
                if (x != 10'(H_PIX)) geom_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) state <= SEEK;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        publish    = 1'b0;
        drop       = 1'b0;
        case (state)
            SEEK: begin
                if (vs_fall) state_next = FRAME;
            end
            FRAME: begin
                if (vs_fall) begin
                    if (y == 9'(V_LINES) && !geom_err) publish = 1'b1;
                    else                                 drop    = 1'b1;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            hex_q      <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                hex_q  <= shadow;
                locked <= 1'b1;
            end else if (drop) begin
                locked <= 1'b0;
            end
        end
    end

    assign fsm_state = (state == FRAME);

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule
